// File: rtl/mdu_iterative.sv
// Multi-cycle RV32M multiply/divide unit feeding the register-file write port.
// Shift-add multiply and restoring divide on magnitudes, then a one-cycle sign-fix step.
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [2:0]       FUNCT3,
    input  logic [WIDTH-1:0] SRCA,
    input  logic [WIDTH-1:0] SRCB,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_funct3;
    logic [WIDTH-1:0]   r_srca;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH:0]     r_rem;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_done;

    logic               w_signed_a;
    logic               w_signed_b;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH+1:0]   w_rem_shift;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_fix_result;

    // Operand signedness: MULH both, MULHSU A only, DIV/REM both.
    assign w_signed_a = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010) ||
                        (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
    assign w_signed_b = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
    assign w_sa       = w_signed_a && SRCA[WIDTH-1];
    assign w_sb       = w_signed_b && SRCB[WIDTH-1];
    assign w_mag_a    = w_sa ? neg_w(SRCA) : SRCA;
    assign w_mag_b    = w_sb ? neg_w(SRCB) : SRCB;

    // Multiplier sits in the low half of r_prod and drains out LSB first.
    assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                         (r_prod[0] ? {1'b0, r_mag_a} : {(WIDTH+1){1'b0}});
    assign w_rem_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_div_ge    = (w_rem_shift >= {2'b00, r_mag_b});

    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? neg_2w(r_prod) : r_prod;
    assign w_div_zero = (r_mag_b == {WIDTH{1'b0}});
    assign w_div_ovf  = r_sign_a && r_sign_b && (r_mag_b == WIDTH'(1)) &&
                        (r_srca == {1'b1, {(WIDTH-1){1'b0}}});
    assign w_quot_fix = (r_sign_a ^ r_sign_b) ? neg_w(r_quot) : r_quot;
    assign w_rem_fix  = r_sign_a ? neg_w(r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];

    // Final-value select applied on the FIX edge
    always_comb begin
        w_fix_result = {WIDTH{1'b0}};
        case (r_funct3)
            3'b000: w_fix_result = w_prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_fix_result = w_prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101: begin
                if (w_div_zero) begin
                    w_fix_result = {WIDTH{1'b1}};
                end else if (w_div_ovf) begin
                    w_fix_result = r_srca;
                end else begin
                    w_fix_result = w_quot_fix;
                end
            end
            3'b110, 3'b111: begin
                if (w_div_zero) begin
                    w_fix_result = r_srca;
                end else if (w_div_ovf) begin
                    w_fix_result = {WIDTH{1'b0}};
                end else begin
                    w_fix_result = w_rem_fix;
                end
            end
            default: w_fix_result = {WIDTH{1'b0}};
        endcase
    end

    // Control FSM with the iterative multiply/divide datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_funct3 <= 3'b000;
            r_srca   <= {WIDTH{1'b0}};
            r_mag_a  <= {WIDTH{1'b0}};
            r_mag_b  <= {WIDTH{1'b0}};
            r_quot   <= {WIDTH{1'b0}};
            r_rem    <= {(WIDTH+1){1'b0}};
            r_prod   <= {(2*WIDTH){1'b0}};
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_funct3 <= FUNCT3;
                        r_srca   <= SRCA;
                        r_sign_a <= w_sa;
                        r_sign_b <= w_sb;
                        r_mag_a  <= w_mag_a;
                        r_mag_b  <= w_mag_b;
                        r_prod   <= {{WIDTH{1'b0}}, w_mag_b};
                        r_quot   <= w_mag_a;
                        r_rem    <= {(WIDTH+1){1'b0}};
                        r_cnt    <= {CW{1'b0}};
                        r_state  <= S_CALC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_prod <= {w_mul_sum, r_prod[WIDTH-1:1]};
                    r_quot <= {r_quot[WIDTH-2:0], w_div_ge};
                    r_rem  <= w_div_ge ? (WIDTH+1)'(w_rem_shift - {2'b00, r_mag_b})
                                       : (WIDTH+1)'(w_rem_shift);
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_CALC;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_result;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY   = (r_state != S_IDLE);
    assign DONE   = r_done;
    assign RESULT = r_result;
endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed vector table, special sequences,
// and randomized operations against an arithmetic reference model.
module tb_mdu_iterative;
    localparam int WIDTH = 32;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [2:0]  FUNCT3;
    logic [31:0] SRCA;
    logic [31:0] SRCB;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    mdu_iterative #(.WIDTH(WIDTH)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .FUNCT3 (FUNCT3),
        .SRCA   (SRCA),
        .SRCB   (SRCB),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          p;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f)
            3'd0: begin up = ua * ub; return 32'(up); end
            3'd1: begin p = sa * sb; return 32'(p >>> 32); end
            3'd2: begin p = sa * longint'(ub); return 32'(p >>> 32); end
            3'd3: begin up = ua * ub; return 32'(up >> 32); end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 32'd0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    // One full operation; latency counts the accepting edge as edge 1.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit inject, input string nm);
        int lat;
        int extra_done;
        lat = 0;
        @(negedge CLK);
        FUNCT3 = f; SRCA = a; SRCB = b; START = 1'b1;
        @(posedge CLK); #1;
        chk({nm, "_busy_accept"}, {31'd0, BUSY}, 32'd1);
        @(negedge CLK);
        START = 1'b0;
        FUNCT3 = 3'($urandom); SRCA = $urandom; SRCB = $urandom;
        for (int k = 2; k <= WIDTH + 8; k++) begin
            START = (inject && k == 10) ? 1'b1 : 1'b0;
            @(posedge CLK); #1;
            if (DONE) begin
                lat = k;
                break;
            end
            @(negedge CLK);
        end
        chk({nm, "_latency"}, 32'(lat), 32'(WIDTH + 2));
        chk({nm, "_result"}, RESULT, exp);
        @(negedge CLK);
        START = inject;
        FUNCT3 = 3'($urandom); SRCA = $urandom; SRCB = $urandom;
        @(posedge CLK); #1;
        chk({nm, "_idle_after"}, {30'd0, BUSY, DONE}, 32'd0);
        chk({nm, "_result_held"}, RESULT, exp);
        @(negedge CLK);
        START = 1'b0;
        if (inject) begin
            extra_done = 0;
            for (int k = 0; k < WIDTH + 4; k++) begin
                @(posedge CLK); #1;
                if (DONE || BUSY) extra_done++;
            end
            chk({nm, "_no_extra_op"}, 32'(extra_done), 32'd0);
            chk({nm, "_result_still"}, RESULT, exp);
        end
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd5, 32'd100,       32'd7,         32'h0000_000E};
        vecs[5]  = '{3'd7, 32'd100,       32'd7,         32'h0000_0002};
        vecs[6]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        vecs[7]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'h0000_0005};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[13] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
        vecs[14] = '{3'd1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
        vecs[15] = '{3'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};

        RST = 1'b1; START = 1'b0; FUNCT3 = 3'd0; SRCA = 32'd0; SRCB = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_state", {BUSY, DONE, 30'd0} | RESULT, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
        end

        // New START during CALC and during the DONE cycle must be dropped.
        run_op(3'd5, 32'd100, 32'd7, 32'h0000_000E, 1'b1, "ignore_start");

        // Reset ten edges into a DIV, with START held to show RST priority.
        @(negedge CLK);
        FUNCT3 = 3'd4; SRCA = 32'hFFFF_FF9C; SRCB = 32'd7; START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1; START = 1'b1;
        @(posedge CLK); #1;
        chk("rst_mid_busy_done", {30'd0, BUSY, DONE}, 32'd0);
        chk("rst_mid_result", RESULT, 32'd0);
        @(posedge CLK); #1;
        chk("rst_over_start", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        RST = 1'b0; START = 1'b0;
        run_op(3'd5, 32'd9, 32'd3, 32'd3, 1'b0, "after_reset");

        for (int i = 0; i < 40; i++) begin
            rf  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else if (sel == 3) ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 300));
            run_op(rf, ra, rb, ref_model(rf, ra, rb), 1'b0, $sformatf("rnd%0d_f%0d", i, rf));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
